readout_frame_sched: RTL and testbench
======================================

Name: readout_frame_sched

Overview:
- Frame-level scheduler that sequences exposure and row readout for the sensor.
- Each frame runs: exposure window, then a one-cycle trigger to the row-readout FSM, then a wait for that FSM's re_busy to rise and fall, then an optional inter-frame gap.
- Runs a programmed number of frames, or runs continuously until stopped.
- Sits between the host/okHost register bank and the readout FSM, in the same CLK domain.

Parameters:
CW, 32, width of the timing/count config inputs and frame counter
ACK_TIMEOUT, 64, max cycles to wait for re_busy rise after trigger (used only with SCHED_TIMEOUT_EN)

Ports:
CLK  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sequence when idle
stop  in  1  one-cycle pulse; end sequence at next frame boundary
num_frames  in  CW  frames per sequence; 0 = continuous until stop
t_exp  in  CW  exposure cycles per frame; 0 treated as 1
t_gap  in  CW  idle cycles between frames; 0 = no gap
re_busy  in  1  busy flag from readout FSM
ro_trigger  out  1  one-cycle trigger pulse to readout FSM
exp_en  out  1  high during exposure window
sched_busy  out  1  high in any state except S_IDLE/S_ERR
frame_cnt  out  CW  frames completed in current sequence
frame_pulse  out  1  one-cycle pulse per completed frame
seq_done  out  1  one-cycle pulse when sequence ends normally
err  out  1  sticky handshake-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - State S_IDLE.
  - All outputs 0, frame_cnt=0.
  - Latched config cleared, stop_pend=0.
  - Reset mid-frame aborts immediately; no further triggers are issued.
- Config latching: num_frames, t_exp and t_gap are latched on an accepted start. Changes to the inputs mid-sequence have no effect.
- S_IDLE:
  - On start=1, latch config, clear frame_cnt, err and stop_pend, then go to S_EXP.
  - start while not idle is ignored.
- S_EXP:
  - exp_en=1 for exactly max(t_exp,1) cycles, timed by counter tmr.
  - Then go to S_TRIG.
- S_TRIG:
  - ro_trigger=1 for exactly one cycle; tmr is cleared.
  - Next state S_WAIT_ACK.
- S_WAIT_ACK:
  - Wait for re_busy=1, then go to S_WAIT_RO.
  - The readout FSM asserts re_busy 2 cycles after trigger; any latency ≥1 is accepted.
  - re_busy already high on entry counts as the ack.
- S_WAIT_RO:
  - Wait for re_busy=0.
  - Then frame_cnt+1 (saturating at all-ones) and frame_pulse=1 for one cycle.
  - Next state is chosen by the end-of-sequence check.
- End-of-sequence check, using the incremented count:
  - Sequence ends if stop_pend=1, or if num_frames≠0 and frame_cnt==num_frames.
  - On end: seq_done=1 for one cycle, go to S_IDLE.
  - Otherwise: go to S_GAP if t_gap≠0, else directly to S_EXP.
- S_GAP: t_gap cycles with all strobes low, then go to S_EXP.
- stop handling:
  - stop is registered into stop_pend in any non-idle state.
  - The current frame always completes: exposure, readout, count increment.
  - stop during S_GAP or S_EXP still finishes that frame.
  - stop in S_IDLE is ignored.
  - start and stop in the same idle cycle: start is accepted, stop is ignored.
- Counters are CW-bit unsigned; tmr compares use ≥ so a config value of all-ones cannot wrap.
- Output registration: outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - In S_WAIT_ACK, if tmr reaches ACK_TIMEOUT without re_busy, go to S_ERR.
  - S_ERR: err=1 (sticky), sched_busy=0, no triggers.
  - Exit S_ERR on start, which clears err and begins a new sequence.
- Undefined:
  - S_WAIT_ACK waits indefinitely.
  - S_ERR is unreachable; err is tied to 0.

Decomposition:
- Package readout_sched_pkg holds:
  - the state enum (S_IDLE, S_EXP, S_TRIG, S_WAIT_ACK, S_WAIT_RO, S_GAP, S_ERR);
  - the CW default;
  - the ACK_TIMEOUT default.
- One natural sub-module: sched_cycle_timer, a loadable CW-bit down-counter with an expiry flag, shared by S_EXP, S_GAP and the ack timeout.
- The FSM stays in the top module.

Test Plan:
- Single-frame, non-zero gap:
  - Stimulus: num_frames=1, t_exp=10, t_gap=5, readout model asserts re_busy 2 cycles after trigger for 40 cycles.
  - Response: exp_en high 10 cycles; exactly one ro_trigger; frame_cnt=1; seq_done once.
- Multi-frame with gap:
  - Stimulus: num_frames=3, t_gap=5.
  - Response: 3 triggers; 5 idle cycles between re_busy fall and the next exp_en; frame_pulse ×3; seq_done after the third.
- Continuous mode with stop during exposure:
  - Stimulus: num_frames=0, stop pulsed during frame 4's exposure.
  - Response: frame 4 completes; frame_cnt=4; no fifth trigger; seq_done=1.
- Reset mid-readout:
  - Stimulus: assert rst_n=0 during S_WAIT_RO.
  - Response: all outputs 0 asynchronously; after release, no trigger until a new start.
- Zero config values:
  - Stimulus: t_exp=0, t_gap=0.
  - Response: exp_en one cycle; next exp_en starts the cycle after re_busy falls.
- Timeout (SCHED_TIMEOUT_EN defined):
  - Stimulus: re_busy held 0, ACK_TIMEOUT=64.
  - Response: err=1 after 64 cycles in S_WAIT_ACK; sched_busy=0; a new start clears err.

Source files
------------

// File: rtl/readout_sched_pkg.sv
// Shared types and defaults for the readout frame scheduler.
//   CW_DEF          : default width of timing/count config and frame counter
//   ACK_TIMEOUT_DEF : default cycles allowed for re_busy to rise after a trigger
//   sched_state_t   : scheduler FSM state encoding
package readout_sched_pkg;

   localparam int CW_DEF          = 32;
   localparam int ACK_TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXP,
      S_TRIG,
      S_WAIT_ACK,
      S_WAIT_RO,
      S_GAP,
      S_ERR
   } sched_state_t;

endpackage

// File: rtl/sched_cycle_timer.sv
// Loadable down-counter shared by exposure, gap and ack-timeout timing.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load; the timer expires load_val+1 cycles after load
//   expired    : count has reached zero (terminal count); holds there
module sched_cycle_timer #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expired
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/readout_frame_sched.sv
// Frame-level scheduler: exposure window, one-cycle readout trigger, wait for
// the readout FSM's busy flag to rise and fall, optional inter-frame gap.
// Runs num_frames frames, or continuously (num_frames=0) until stop.
//
// Optional build macro: SCHED_TIMEOUT_EN enables the ack timeout and S_ERR.
//
// Ports:
//   CLK, rst_n  : system clock, asynchronous active-low reset
//   start, stop : one-cycle control pulses
//   num_frames  : frames per sequence (0 = continuous)
//   t_exp       : exposure cycles (0 behaves as 1)
//   t_gap       : gap cycles between frames (0 = none)
//   re_busy     : busy flag from readout FSM
//   ro_trigger  : one-cycle trigger to readout FSM
//   exp_en      : exposure window
//   sched_busy  : sequence in progress
//   frame_cnt   : frames completed in current sequence
//   frame_pulse : one pulse per completed frame
//   seq_done    : one pulse at normal end of sequence
//   err         : sticky handshake timeout
//
// state      | meaning
// S_IDLE     | waiting for start
// S_EXP      | exposure window, exp_en high
// S_TRIG     | single-cycle readout trigger
// S_WAIT_ACK | waiting for re_busy to rise
// S_WAIT_RO  | waiting for re_busy to fall (frame completes)
// S_GAP      | inter-frame idle gap
// S_ERR      | ack timeout, waiting for a new start
module readout_frame_sched
   import readout_sched_pkg::*;
#(
   parameter int CW          = CW_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] num_frames,
   input  logic [CW-1:0] t_exp,
   input  logic [CW-1:0] t_gap,
   input  logic          re_busy,
   output logic          ro_trigger,
   output logic          exp_en,
   output logic          sched_busy,
   output logic [CW-1:0] frame_cnt,
   output logic          frame_pulse,
   output logic          seq_done,
   output logic          err
);

   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] ACK_TC  = CW'(ACK_TIMEOUT - 1);

   sched_state_t  state_q, state_nxt;
   logic [CW-1:0] num_frames_q, t_exp_q, t_gap_q;
   logic          stop_pend;
   logic [CW-1:0] cnt_nxt, exp_src;
   logic          pulse_nxt, done_nxt, cfg_load;
   logic          tmr_load, tmr_expired;
   logic [CW-1:0] tmr_val;

   sched_cycle_timer #(.CW(CW)) u_tmr (
      .clk      (CLK),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = frame_cnt;
      pulse_nxt = 1'b0;
      done_nxt  = 1'b0;
      cfg_load  = 1'b0;
      unique case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               cfg_load  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_EXP;
            end
         end
         S_EXP:      if (tmr_expired) state_nxt = S_TRIG;
         S_TRIG:     state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (re_busy) state_nxt = S_WAIT_RO;
`ifdef SCHED_TIMEOUT_EN
            else if (tmr_expired) state_nxt = S_ERR;
`endif
         end
         S_WAIT_RO: begin
            if (!re_busy) begin
               cnt_nxt   = (frame_cnt == '1) ? frame_cnt : frame_cnt + ONE;
               pulse_nxt = 1'b1;
               // End check uses the incremented count.
               if (stop_pend || ((num_frames_q != '0) && (cnt_nxt == num_frames_q))) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end else if (t_gap_q != '0) begin
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_EXP;
               end
            end
         end
         S_GAP:   if (tmr_expired) state_nxt = S_EXP;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The timer is loaded on every state change with (duration - 1) of the
   // state being entered; on the accepting start the config is not latched
   // yet, so the exposure length comes straight from the input.
   always_comb begin
      exp_src  = cfg_load ? t_exp : t_exp_q;
      tmr_load = (state_nxt != state_q);
      tmr_val  = '0;
      unique case (state_nxt)
         S_EXP:      tmr_val = (exp_src == '0) ? '0 : exp_src - ONE;
         S_GAP:      tmr_val = t_gap_q - ONE;
         S_WAIT_ACK: tmr_val = ACK_TC;
         default:    tmr_val = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         num_frames_q <= '0;
         t_exp_q      <= '0;
         t_gap_q      <= '0;
         stop_pend    <= 1'b0;
         frame_cnt    <= '0;
         frame_pulse  <= 1'b0;
         seq_done     <= 1'b0;
         exp_en       <= 1'b0;
         ro_trigger   <= 1'b0;
         sched_busy   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (cfg_load) begin
            num_frames_q <= num_frames;
            t_exp_q      <= t_exp;
            t_gap_q      <= t_gap;
         end
         if (cfg_load) begin
            stop_pend <= 1'b0;
         end else if ((state_q != S_IDLE) && (state_q != S_ERR) && stop) begin
            stop_pend <= 1'b1;
         end
         frame_cnt   <= cnt_nxt;
         frame_pulse <= pulse_nxt;
         seq_done    <= done_nxt;
         exp_en      <= (state_nxt == S_EXP);
         ro_trigger  <= (state_nxt == S_TRIG);
         sched_busy  <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
      end
   end

`ifdef SCHED_TIMEOUT_EN
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= (state_nxt == S_ERR);
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_readout_frame_sched.sv
// Bench for readout_frame_sched: table of directed sequences, randomized
// sequences against a timeline model, and hand-written reset / no-ack cases.
module tb_readout_frame_sched;

   localparam int CW   = 32;
   localparam int MAXC = 512;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, re_busy = 1'b0;
   logic [CW-1:0] num_frames = '0, t_exp = '0, t_gap = '0;
   logic          ro_trigger, exp_en, sched_busy, frame_pulse, seq_done, err;
   logic [CW-1:0] frame_cnt;

   int checks = 0;
   int failures = 0;
   int last_cnt = 0;

   always #5 CLK = ~CLK;

   readout_frame_sched #(.CW(CW), .ACK_TIMEOUT(64)) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .num_frames  (num_frames),
      .t_exp       (t_exp),
      .t_gap       (t_gap),
      .re_busy     (re_busy),
      .ro_trigger  (ro_trigger),
      .exp_en      (exp_en),
      .sched_busy  (sched_busy),
      .frame_cnt   (frame_cnt),
      .frame_pulse (frame_pulse),
      .seq_done    (seq_done),
      .err         (err)
   );

   // Expected per-cycle timeline; cycle 0 is the cycle start is driven.
   bit m_exp [MAXC];
   bit m_trig [MAXC];
   bit m_busy [MAXC];
   bit m_pulse [MAXC];
   bit m_done [MAXC];
   bit m_rb [MAXC];
   int m_cnt [MAXC];
   int m_len;
   int m_stop_cyc;

   typedef struct {
      int nf, texp, tgap, lat, blen, stopf;
      int e_trig, e_exp, e_cnt, e_done;
   } vec_t;

   task automatic chk(input string name, input int idx, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, idx, act, req);
      end
   endtask

   // Frame timeline from the scheduling rules: exposure of max(t_exp,1)
   // cycles, trigger, readout handshake, frame completion the cycle after
   // re_busy is seen low, then gap or end. stopf: 0 none, -1 together with
   // start (ignored), k = pulse in the first exposure cycle of frame k.
   // A stop counts for a frame if it arrives at least two cycles before
   // that frame's completion cycle.
   function automatic void build_model(int nf, int texp, int tgap, int lat, int blen, int stopf);
      int n, cur, t, c, cnt, f;
      bit fin;
      for (int i = 0; i < MAXC; i++) begin
         m_exp[i] = 0; m_trig[i] = 0; m_busy[i] = 0;
         m_pulse[i] = 0; m_done[i] = 0; m_rb[i] = 0;
         m_cnt[i] = (i == 0) ? last_cnt : 0;
      end
      n = (texp == 0) ? 1 : texp;
      cur = 1; cnt = 0; f = 0; fin = 0; m_len = 0;
      m_stop_cyc = (stopf < 0) ? 0 : -1;
      while (!fin) begin
         f++;
         if (f == stopf) m_stop_cyc = cur;
         for (int i = cur; i < cur + n; i++) begin m_exp[i] = 1; m_busy[i] = 1; end
         t = cur + n;
         m_trig[t] = 1;
         c = t + lat + blen + 1;
         for (int i = t; i < c; i++) m_busy[i] = 1;
         for (int i = t + lat; i < t + lat + blen; i++) m_rb[i] = 1;
         cnt++;
         m_pulse[c] = 1;
         for (int i = c; i < MAXC; i++) m_cnt[i] = cnt;
         if ((m_stop_cyc >= 1 && m_stop_cyc <= c - 2) || (nf != 0 && cnt == nf)) begin
            m_done[c] = 1;
            fin = 1;
            m_len = c + 3;
         end else begin
            for (int i = c; i < c + tgap; i++) m_busy[i] = 1;
            cur = c + tgap;
         end
      end
   endfunction

   task automatic run_seq(input int nf, input int texp, input int tgap, input int lat,
                          input int blen, input int stopf, input string tag,
                          output int n_trig, output int n_exp, output int n_pulse,
                          output int n_done, output int fcnt);
      build_model(nf, texp, tgap, lat, blen, stopf);
      n_trig = 0; n_exp = 0; n_pulse = 0; n_done = 0;
      for (int i = 0; i < m_len; i++) begin
         @(posedge CLK); #1;
         // Second start at cycle 2 falls inside the sequence and must be ignored,
         // as must the scrambled config after the accepting start.
         start   = (i == 0) || (i == 2);
         stop    = (i == m_stop_cyc);
         re_busy = m_rb[i];
         if (i == 0) begin
            num_frames = CW'(nf); t_exp = CW'(texp); t_gap = CW'(tgap);
         end else begin
            num_frames = $urandom; t_exp = $urandom; t_gap = $urandom;
         end
         @(negedge CLK);
         chk({tag, "_exp_en"},      i, exp_en,      m_exp[i]);
         chk({tag, "_ro_trigger"},  i, ro_trigger,  m_trig[i]);
         chk({tag, "_sched_busy"},  i, sched_busy,  m_busy[i]);
         chk({tag, "_frame_pulse"}, i, frame_pulse, m_pulse[i]);
         chk({tag, "_seq_done"},    i, seq_done,    m_done[i]);
         chk({tag, "_frame_cnt"},   i, frame_cnt,   m_cnt[i]);
         chk({tag, "_err"},         i, err,         0);
         n_trig  += int'(ro_trigger);
         n_exp   += int'(exp_en);
         n_pulse += int'(frame_pulse);
         n_done  += int'(seq_done);
      end
      fcnt = int'(frame_cnt);
      last_cnt = m_cnt[m_len - 1];
      start = 0; stop = 0; re_busy = 0;
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      rst_n = 0; start = 0; stop = 0; re_busy = 0;
      @(posedge CLK); #1;
      rst_n = 1;
      last_cnt = 0;
   endtask

   vec_t tbl [6];
   int n_trig, n_exp, n_pulse, n_done, fcnt;

   initial begin
      tbl[0] = '{nf:1, texp:10, tgap:5, lat:2, blen:40, stopf:0, e_trig:1, e_exp:10, e_cnt:1, e_done:1};
      tbl[1] = '{nf:3, texp:4,  tgap:5, lat:2, blen:6,  stopf:0, e_trig:3, e_exp:12, e_cnt:3, e_done:1};
      tbl[2] = '{nf:0, texp:6,  tgap:3, lat:2, blen:5,  stopf:4, e_trig:4, e_exp:24, e_cnt:4, e_done:1};
      tbl[3] = '{nf:2, texp:0,  tgap:0, lat:1, blen:3,  stopf:0, e_trig:2, e_exp:2,  e_cnt:2, e_done:1};
      tbl[4] = '{nf:2, texp:3,  tgap:0, lat:3, blen:1,  stopf:1, e_trig:1, e_exp:3,  e_cnt:1, e_done:1};
      tbl[5] = '{nf:2, texp:2,  tgap:1, lat:2, blen:2,  stopf:-1, e_trig:2, e_exp:4, e_cnt:2, e_done:1};

      // Reset state
      repeat (2) @(posedge CLK);
      #2;
      chk("rst_exp_en", 0, exp_en, 0);
      chk("rst_ro_trigger", 0, ro_trigger, 0);
      chk("rst_sched_busy", 0, sched_busy, 0);
      chk("rst_frame_cnt", 0, frame_cnt, 0);
      chk("rst_seq_done", 0, seq_done, 0);
      chk("rst_err", 0, err, 0);
      @(posedge CLK); #1;
      rst_n = 1;

      // Directed table
      foreach (tbl[k]) begin
         run_seq(tbl[k].nf, tbl[k].texp, tbl[k].tgap, tbl[k].lat, tbl[k].blen, tbl[k].stopf,
                 "tbl", n_trig, n_exp, n_pulse, n_done, fcnt);
         chk("tbl_triggers", k, n_trig, tbl[k].e_trig);
         chk("tbl_exp_cycles", k, n_exp, tbl[k].e_exp);
         chk("tbl_frame_pulses", k, n_pulse, tbl[k].e_cnt);
         chk("tbl_seq_done", k, n_done, tbl[k].e_done);
         chk("tbl_final_cnt", k, fcnt, tbl[k].e_cnt);
      end

      // Randomized sequences
      for (int r = 0; r < 20; r++) begin
         int nf, stopf;
         nf    = int'($urandom_range(0, 4));
         stopf = (nf == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, nf + 1));
         run_seq(nf, int'($urandom_range(0, 20)), int'($urandom_range(0, 8)),
                 int'($urandom_range(1, 6)), int'($urandom_range(1, 20)), stopf,
                 "rnd", n_trig, n_exp, n_pulse, n_done, fcnt);
      end

      // Reset during readout: outputs clear asynchronously, no trigger afterwards
      @(posedge CLK); #1;
      start = 1; num_frames = 1; t_exp = 3; t_gap = 0;
      @(posedge CLK); #1;
      start = 0;
      repeat (5) @(posedge CLK);
      #1 re_busy = 1;
      repeat (4) @(posedge CLK);
      #3;
      chk("mid_busy_before_rst", 0, sched_busy, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_exp_en", 0, exp_en, 0);
      chk("mid_rst_ro_trigger", 0, ro_trigger, 0);
      chk("mid_rst_sched_busy", 0, sched_busy, 0);
      chk("mid_rst_frame_cnt", 0, frame_cnt, 0);
      chk("mid_rst_frame_pulse", 0, frame_pulse, 0);
      chk("mid_rst_seq_done", 0, seq_done, 0);
      @(posedge CLK); #1;
      rst_n = 1; re_busy = 0;
      last_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("post_rst_ro_trigger", i, ro_trigger, 0);
         chk("post_rst_sched_busy", i, sched_busy, 0);
         chk("post_rst_exp_en", i, exp_en, 0);
      end

      // No ack from readout: trigger at cycle 3, waiting from cycle 4
      @(posedge CLK); #1;
      start = 1; num_frames = 1; t_exp = 2; t_gap = 0; re_busy = 0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge CLK); #1;
         start = 0;
         @(negedge CLK);
`ifdef SCHED_TIMEOUT_EN
         chk("to_err", i, err, (i >= 68) ? 1 : 0);
         chk("to_sched_busy", i, sched_busy, (i < 68) ? 1 : 0);
`else
         chk("noack_err", i, err, 0);
         chk("noack_sched_busy", i, sched_busy, 1);
`endif
         chk("noack_trigger", i, ro_trigger, (i == 3) ? 1 : 0);
      end
`ifdef SCHED_TIMEOUT_EN
      @(posedge CLK); #1;
      start = 1;
      @(posedge CLK); #1;
      start = 0;
      @(negedge CLK);
      chk("to_restart_err", 0, err, 0);
      chk("to_restart_busy", 0, sched_busy, 1);
      chk("to_restart_exp_en", 0, exp_en, 1);
`endif
      do_reset();

      // Recovery after reset: a normal frame runs again
      run_seq(1, 2, 0, 2, 3, 0, "after", n_trig, n_exp, n_pulse, n_done, fcnt);
      chk("after_triggers", 0, n_trig, 1);
      chk("after_final_cnt", 0, fcnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
